// File: rtl/adder_subtractor_4bit_reg.sv
// adder_subtractor_4bit_reg
// 4-bit two's-complement adder/subtractor with one output register stage.
// sel=0 gives S = A + B. sel=1 gives S = A - B, computed as A + ~B + 1.
// The core is a ripple chain of four full adders. B is inverted by XOR with sel,
// and sel is also the carry-in.
// Optional feature macro: ADDSUB_OVF_EN adds a registered signed-overflow output, ovf.

module adder_subtractor_4bit_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       sel,
   input  logic       in_valid,
   output logic [3:0] S,
   output logic       cout,
   output logic       out_valid
`ifdef ADDSUB_OVF_EN
   ,
   output logic       ovf
`endif
);

   logic [3:0] w_bx;
   logic [4:0] w_carry;
   logic [3:0] w_sum;

   logic [3:0] r_sum;
   logic       r_cout;
   logic       r_outValid;

   // Subtraction uses B's ones' complement, and sel supplies the +1 carry-in.
   assign w_bx       = B ^ {4{sel}};
   assign w_carry[0] = sel;

   // Four full adders chained from bit 0 to bit 3.
   for (genvar i = 0; i < 4; i++) begin : gRipple
      assign w_sum[i]       = A[i] ^ w_bx[i] ^ w_carry[i];
      assign w_carry[i + 1] = (A[i] & w_bx[i]) | (w_carry[i] & (A[i] ^ w_bx[i]));
   end

   // Capture the result only on valid cycles; out_valid follows in_valid on every edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum      <= 4'b0000;
         r_cout     <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         r_outValid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_carry[4];
         end
      end
   end

   assign S         = r_sum;
   assign cout      = r_cout;
   assign out_valid = r_outValid;

`ifdef ADDSUB_OVF_EN
   logic r_ovf;

   // Signed overflow happens when the carries into and out of the sign bit differ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (in_valid) begin
         r_ovf <= w_carry[3] ^ w_carry[4];
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_adder_subtractor_4bit_reg.sv
// tb_adder_subtractor_4bit_reg
// Scoreboard bench for adder_subtractor_4bit_reg.
// The stimulus process pushes the expected {ovf, cout, S} for each issued operation.
// The monitor pops an entry and compares it at every negedge where out_valid is high.
// On idle cycles, the monitor checks that the last result is held.

module tb_adder_subtractor_4bit_reg;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       sel;
   logic       in_valid;
   logic [3:0] S;
   logic       cout;
   logic       out_valid;
`ifdef ADDSUB_OVF_EN
   logic       ovf;
`endif

   int assertCount = 0;
   int failCount   = 0;

   logic [5:0] expQ[$];
   logic [5:0] lastExp = 6'b0;

   adder_subtractor_4bit_reg dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .in_valid  (in_valid),
      .S         (S),
      .cout      (cout),
      .out_valid (out_valid)
`ifdef ADDSUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model, written as plain integer arithmetic rather than a carry chain.
   function automatic logic [5:0] modelResult(input logic [3:0] a, input logic [3:0] b,
                                              input logic s);
      int ua, ub, sa, sb, sr, ur;
      logic [3:0] rs;
      logic rc, ro;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      if (s) begin
         ur = ua + 16 - ub;
         rc = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub;
         rc = (ur > 15);
         sr = sa + sb;
      end
      rs = 4'(ur % 16);
      ro = (sr > 7) || (sr < -8);
      return {ro, rc, rs};
   endfunction

   task automatic checkValue(input string name, input logic [3:0] got, input logic [3:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [5:0] exp);
      logic ok;
      ok = (S === exp[3:0]) && (cout === exp[4]);
`ifdef ADDSUB_OVF_EN
      ok = ok && (ovf === exp[5]);
`endif
      assertCount++;
      if (!ok) begin
         failCount++;
`ifdef ADDSUB_OVF_EN
         $display("[TB] FAIL %s: got S=%h cout=%b ovf=%b, expected S=%h cout=%b ovf=%b",
                  name, S, cout, ovf, exp[3:0], exp[4], exp[5]);
`else
         $display("[TB] FAIL %s: got S=%h cout=%b, expected S=%h cout=%b (ovf bit %b unused)",
                  name, S, cout, exp[3:0], exp[4], exp[5]);
`endif
      end
   endtask

   // Issue one operation, record its expected response, and return just after the capture edge.
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic s,
                                input logic [5:0] exp);
      A        = a;
      B        = b;
      sel      = s;
      in_valid = 1'b1;
      expQ.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares on valid outputs, and checks held values on idle cycles.
   always @(negedge clk) begin
      if (rst) begin
         lastExp = 6'b0;
      end else if (out_valid) begin
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected no pending result");
         end else begin
            lastExp = expQ.pop_front();
            checkOutput("result", lastExp);
         end
      end else begin
         checkOutput("hold", lastExp);
      end
   end

   // Directed vectors, hold, mid-run reset and exhaustive sweep.
   initial begin
      rst      = 1'b1;
      A        = 4'h0;
      B        = 4'h0;
      sel      = 1'b0;
      in_valid = 1'b0;
      #3;
      checkValue("reset_S", S, 4'h0);
      checkValue("reset_cout", {3'b0, cout}, 4'h0);
      checkValue("reset_out_valid", {3'b0, out_valid}, 4'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Expected values below are hand computed as {ovf, cout, S}.
      applyStimulus(4'h6, 4'h2, 1'b0, {1'b1, 1'b0, 4'h8});
      applyStimulus(4'hD, 4'hC, 1'b0, {1'b0, 1'b1, 4'h9});
      applyStimulus(4'h6, 4'h2, 1'b1, {1'b0, 1'b1, 4'h4});
      applyStimulus(4'h2, 4'h6, 1'b1, {1'b0, 1'b0, 4'hC});
      applyStimulus(4'hF, 4'h5, 1'b1, {1'b0, 1'b1, 4'hA});
      applyStimulus(4'hC, 4'hC, 1'b1, {1'b0, 1'b1, 4'h0});
      applyStimulus(4'h6, 4'h6, 1'b0, {1'b1, 1'b0, 4'hC});
      applyStimulus(4'h0, 4'h0, 1'b1, {1'b0, 1'b1, 4'h0});
      applyStimulus(4'hF, 4'h1, 1'b0, {1'b0, 1'b1, 4'h0});
      applyStimulus(4'h8, 4'h1, 1'b1, {1'b1, 1'b1, 4'h7});

      // Hold: new operands with in_valid low must not disturb S.
      applyStimulus(4'h5, 4'hF, 1'b0, {1'b0, 1'b1, 4'h4});
      A        = 4'h3;
      B        = 4'h9;
      sel      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkValue("hold_out_valid", {3'b0, out_valid}, 4'h0);
      checkValue("hold_S", S, 4'h4);
      repeat (2) @(posedge clk);
      #1;

      // Reset during operation clears outputs without waiting for a clock edge.
      applyStimulus(4'hD, 4'hC, 1'b0, {1'b0, 1'b1, 4'h9});
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkValue("midreset_S", S, 4'h0);
      checkValue("midreset_cout", {3'b0, cout}, 4'h0);
      checkValue("midreset_out_valid", {3'b0, out_valid}, 4'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Exhaustive sweep against the integer reference model.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int s = 0; s < 2; s++) begin
               applyStimulus(4'(a), 4'(b), 1'(s), modelResult(4'(a), 4'(b), 1'(s)));
            end
         end
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
